// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch requester and the
// load/store requester. Conflicts are resolved round-robin. One memory
// transaction is in flight at a time, and it is sequenced by a small FSM.
//
// Ports
//   clk, n_rst                  clock; synchronous active-low reset
//   fetch_req_valid/_ready      fetch read request handshake
//   fetch_addr                  fetch byte address
//   fetch_resp_valid/_data      one-cycle response pulse and its held data
//   data_req_valid/_ready       load/store request handshake
//   data_we, data_addr,
//   data_wdata                  store flag, byte address, store data
//   data_resp_valid/_data       one-cycle response pulse; data is 0 for stores
//   mem_req, mem_we, mem_addr,
//   mem_wdata                   memory strobe and command (all zero when idle)
//   mem_rdata                   memory read data, valid READ_LATENCY cycles after mem_req
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            fetch_req_valid,
   output logic            fetch_req_ready,
   input  logic [XLEN-1:0] fetch_addr,
   output logic            fetch_resp_valid,
   output logic [XLEN-1:0] fetch_resp_data,
   input  logic            data_req_valid,
   output logic            data_req_ready,
   input  logic            data_we,
   input  logic [XLEN-1:0] data_addr,
   input  logic [XLEN-1:0] data_wdata,
   output logic            data_resp_valid,
   output logic [XLEN-1:0] data_resp_data,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [3:0] RL = 4'(READ_LATENCY);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            last_grant;   // 0 = fetch, 1 = data
   logic            owner;        // 0 = fetch, 1 = data
   logic            we_r;
   logic [XLEN-1:0] addr_r;
   logic [XLEN-1:0] wdata_r;
   logic [XLEN-1:0] fetch_rdata_r;
   logic [XLEN-1:0] data_rdata_r;
   logic            arb_state;
   logic            grant_fetch;
   logic            grant_data;

   // Ready is masked during reset so that no handshake completes which the
   // reset would then silently drop.
   always_comb begin
      arb_state   = (state == IDLE) || (state == RESP);
      grant_fetch = n_rst && arb_state && fetch_req_valid &&
                    (!data_req_valid || last_grant);
      grant_data  = n_rst && arb_state && data_req_valid &&
                    (!fetch_req_valid || !last_grant);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE, RESP: begin
            if (grant_fetch || grant_data) state_nxt = ISSUE;
            else                           state_nxt = IDLE;
         end
         ISSUE: begin
            if (we_r) begin
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = 4'd1;
            end
         end
         WAIT: begin
            if (cnt == RL) state_nxt = RESP;
            else           cnt_nxt   = cnt + 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state         <= IDLE;
         cnt           <= '0;
         last_grant    <= 1'b0;
         owner         <= 1'b0;
         we_r          <= 1'b0;
         addr_r        <= '0;
         wdata_r       <= '0;
         fetch_rdata_r <= '0;
         data_rdata_r  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant_fetch || grant_data) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            we_r       <= grant_data & data_we;
            addr_r     <= grant_data ? data_addr  : fetch_addr;
            wdata_r    <= grant_data ? data_wdata : '0;
         end
         // Only the data requester can issue a write, so a store clears its
         // response register.
         if (state == ISSUE && we_r) data_rdata_r <= '0;
         if (state == WAIT && cnt == RL) begin
            if (owner) data_rdata_r  <= mem_rdata;
            else       fetch_rdata_r <= mem_rdata;
         end
      end
   end

   assign fetch_req_ready  = grant_fetch;
   assign data_req_ready   = grant_data;
   assign mem_req          = (state == ISSUE);
   assign mem_we           = mem_req & we_r;
   assign mem_addr         = mem_req ? addr_r  : '0;
   assign mem_wdata        = mem_req ? wdata_r : '0;
   assign fetch_resp_valid = (state == RESP) && !owner;
   assign data_resp_valid  = (state == RESP) && owner;
   assign fetch_resp_data  = fetch_rdata_r;
   assign data_resp_data   = data_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int XLEN = 32;
   localparam int RL   = 2;

   logic            clk = 1'b0;
   logic            n_rst = 1'b0;
   logic            fetch_req_valid = 1'b0;
   logic            fetch_req_ready;
   logic [XLEN-1:0] fetch_addr = '0;
   logic            fetch_resp_valid;
   logic [XLEN-1:0] fetch_resp_data;
   logic            data_req_valid = 1'b0;
   logic            data_req_ready;
   logic            data_we = 1'b0;
   logic [XLEN-1:0] data_addr = '0;
   logic [XLEN-1:0] data_wdata = '0;
   logic            data_resp_valid;
   logic [XLEN-1:0] data_resp_data;
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(XLEN), .READ_LATENCY(RL)) dut (
      .clk(clk), .n_rst(n_rst),
      .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
      .fetch_addr(fetch_addr),
      .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
      .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
      .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Transaction-level reference: one outstanding transaction, described by
   // the cycle numbers at which its events must happen.
   bit          t_act = 0;
   bit          t_owner;        // 0 fetch, 1 data
   bit          t_we;
   logic [31:0] t_addr, t_wdata, t_rdata;
   int          t_req_c, t_samp_c, t_resp_c;
   bit          lastg = 0;      // 0 fetch, 1 data
   logic [31:0] m_fdata = '0, m_ddata = '0;
   logic [31:0] memimg [logic [31:0]];
   bit          acc_f, acc_d;

   function automatic logic [31:0] mem_read(logic [31:0] a);
      if (memimg.exists(a)) return memimg[a];
      return (a * 32'h9E3779B1) ^ 32'hA5C30F96;
   endfunction

   task automatic run_cycle();
      logic free, ef, ed, emr, emw, efv, edv;
      logic [31:0] ema, emd;
      acc_f = 0;
      acc_d = 0;
      @(negedge clk);
      if (n_rst) begin
         if (t_act && cyc == t_resp_c) begin
            if (!t_owner) m_fdata = t_rdata;
            else          m_ddata = t_we ? 32'h0 : t_rdata;
         end
         free = !t_act || (cyc >= t_resp_c);
         ef  = free && fetch_req_valid && (!data_req_valid || lastg);
         ed  = free && data_req_valid && (!fetch_req_valid || !lastg);
         emr = t_act && (cyc == t_req_c);
         emw = emr && t_we;
         ema = emr ? t_addr  : 32'h0;
         emd = emr ? t_wdata : 32'h0;
         efv = t_act && (cyc == t_resp_c) && !t_owner;
         edv = t_act && (cyc == t_resp_c) && t_owner;

         n_total++;
         if ({fetch_req_ready, data_req_ready} !== {ef, ed})
            $display("FAIL ready cyc=%0d got f=%b d=%b exp f=%b d=%b", cyc,
                     fetch_req_ready, data_req_ready, ef, ed);
         else n_pass++;
         n_total++;
         if ((fetch_req_ready & data_req_ready) !== 1'b0)
            $display("FAIL ready_onehot cyc=%0d got both high exp at most one", cyc);
         else n_pass++;
         n_total++;
         if ({mem_req, mem_we, mem_addr, mem_wdata} !== {emr, emw, ema, emd})
            $display("FAIL mem_cmd cyc=%0d got req=%b we=%b a=%h d=%h exp req=%b we=%b a=%h d=%h",
                     cyc, mem_req, mem_we, mem_addr, mem_wdata, emr, emw, ema, emd);
         else n_pass++;
         n_total++;
         if ({fetch_resp_valid, data_resp_valid} !== {efv, edv})
            $display("FAIL resp_valid cyc=%0d got f=%b d=%b exp f=%b d=%b", cyc,
                     fetch_resp_valid, data_resp_valid, efv, edv);
         else n_pass++;
         n_total++;
         if (fetch_resp_data !== m_fdata)
            $display("FAIL fetch_resp_data cyc=%0d got %h exp %h", cyc, fetch_resp_data, m_fdata);
         else n_pass++;
         n_total++;
         if (data_resp_data !== m_ddata)
            $display("FAIL data_resp_data cyc=%0d got %h exp %h", cyc, data_resp_data, m_ddata);
         else n_pass++;

         if (t_act && cyc == t_resp_c) t_act = 0;
         if (ef || ed) begin
            t_act    = 1;
            t_owner  = ed;
            t_we     = ed && data_we;
            t_addr   = ed ? data_addr : fetch_addr;
            t_wdata  = ed ? data_wdata : 32'h0;
            t_rdata  = t_we ? 32'h0 : mem_read(t_addr);
            if (t_we) memimg[t_addr] = t_wdata;
            t_req_c  = cyc + 1;
            t_samp_c = cyc + 1 + RL;
            t_resp_c = t_we ? cyc + 2 : cyc + 2 + RL;
            lastg    = ed;
         end
         acc_f = ef;
         acc_d = ed;
      end else begin
         t_act   = 0;
         lastg   = 0;
         m_fdata = '0;
         m_ddata = '0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc_f) fetch_req_valid = 0;
      if (acc_d) data_req_valid = 0;
      // Garbage on every cycle except the one the data is due.
      mem_rdata = (t_act && !t_we && cyc == t_samp_c) ? t_rdata : $urandom;
   endtask

   task automatic gen(int pf, int pd, int pw);
      if (!fetch_req_valid && $urandom_range(99) < pf) begin
         fetch_req_valid = 1;
         fetch_addr      = 32'($urandom_range(0, 15)) << 2;
      end
      if (!data_req_valid && $urandom_range(99) < pd) begin
         data_req_valid = 1;
         data_we        = ($urandom_range(99) < pw);
         data_addr      = 32'($urandom_range(0, 15)) << 2;
         data_wdata     = $urandom;
      end
   endtask

   task automatic do_reset();
      n_rst = 0;
      run_cycle();
      run_cycle();
      n_rst = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (fetch_req_valid || data_req_valid || t_act); i++)
         run_cycle();
   endtask

   task automatic test_reset();
      do_reset();
      run_cycle();
      run_cycle();
   endtask

   task automatic test_fetch_read();
      memimg[32'h10] = 32'h00500093;
      fetch_addr      = 32'h10;
      fetch_req_valid = 1;
      for (int i = 0; i < RL + 4; i++) run_cycle();
      n_total++;
      if (fetch_resp_data !== 32'h00500093)
         $display("FAIL fetch_word got %h exp %h", fetch_resp_data, 32'h00500093);
      else n_pass++;
   endtask

   task automatic test_store();
      data_we        = 1;
      data_addr      = 32'h100;
      data_wdata     = 32'hDEADBEEF;
      data_req_valid = 1;
      for (int i = 0; i < 4; i++) run_cycle();
      n_total++;
      if (data_resp_data !== 32'h0)
         $display("FAIL store_resp_data got %h exp %h", data_resp_data, 32'h0);
      else n_pass++;
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 6 * (RL + 2); i++) begin
         gen(100, 100, 0);
         run_cycle();
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4 * (RL + 2); i++) begin
         gen(100, 0, 0);
         run_cycle();
      end
      drain();
   endtask

   task automatic test_reset_in_wait();
      run_cycle();
      fetch_addr      = 32'h24;
      fetch_req_valid = 1;
      run_cycle();          // T: accepted
      run_cycle();          // T+1: ISSUE
      run_cycle();          // T+2: WAIT
      n_rst = 0;
      run_cycle();          // T+3: reset sampled
      n_rst = 1;
      run_cycle();
      run_cycle();
      for (int i = 0; i < RL + 3; i++) begin
         gen(100, 100, 0);
         run_cycle();
      end
      drain();
   endtask

   task automatic test_idle();
      drain();
      for (int i = 0; i < 10; i++) run_cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         gen(40, 40, 50);
         run_cycle();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_store();
      test_contention();
      test_back_to_back();
      test_reset_in_wait();
      test_idle();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
